// File: rtl/udp_pkg.sv
// Shared Ethernet/UDP definitions: receive FSM states and framing/CRC constants.
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_FRAME    = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step over one byte, reflected polynomial, LSB first.
module crc32_d8
  import udp_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_framer.sv
// GMII receive framer: preamble/SFD detect, FCS strip via 5-byte delay line,
// CRC-32 / length / rx_er checks flagged on the last emitted byte.
module eth_rx_framer
  import udp_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       out_err
);

  localparam int CW = $clog2(MAX_FRAME + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_FRAME);
  localparam logic [2:0]    DL_FULL = 3'd5;

  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0][7:0] dl_q, dl_d;
  logic [2:0]      fill_q, fill_d;
  logic [31:0]     crc_q, crc_d, crc_nxt;
  logic            err_q, err_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            out_err_q, out_err_d;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (rx_data),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dl_d        = dl_q;
    fill_d      = fill_q;
    crc_d       = crc_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_dv)
          state_d = (rx_data == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (rx_data == ETH_SFD) begin
          state_d = ST_FRAME;
          crc_d   = '1;
          cnt_d   = '0;
          fill_d  = '0;
          err_d   = 1'b0;
        end else if (rx_data != ETH_PREAMBLE) begin
          state_d = ST_DROP;
        end
      end
      ST_FRAME: begin
        if (rx_dv) begin
          crc_d = crc_nxt;
          dl_d  = {dl_q[3:0], rx_data};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
          if (fill_q != DL_FULL) fill_d = fill_q + 3'd1;
          if (rx_er) err_d = 1'b1;
          if (fill_q == DL_FULL) begin
            out_valid_d = 1'b1;
            out_data_d  = dl_q[4];
          end
          // Oversize: close the frame on the byte that crosses the limit
          if (cnt_q == CNT_MAX) begin
            state_d = ST_DROP;
            if (fill_q == DL_FULL) begin
              out_last_d = 1'b1;
              out_err_d  = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
          if (fill_q == DL_FULL) begin
            out_valid_d = 1'b1;
            out_data_d  = dl_q[4];
            out_last_d  = 1'b1;
            out_err_d   = (crc_q != CRC32_RESIDUE) | err_q
                        | (cnt_q < CNT_MIN);
          end
        end
      end
      ST_DROP: begin
        if (!rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dl_q        <= '0;
      fill_q      <= '0;
      crc_q       <= '1;
      err_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dl_q        <= dl_d;
      fill_q      <= fill_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule
